// File: rtl/regfile_pkg.sv
// Shared defaults and types for the multi-port MIPS register file.
package regfile_pkg;

  localparam int unsigned DEF_XLEN  = 32;
  localparam int unsigned DEF_NREGS = 32;
  localparam int unsigned DEF_NRD   = 2;
  localparam int unsigned DEF_NWR   = 2;

  function automatic int unsigned addr_width(input int unsigned nregs);
    return (nregs <= 2) ? 1 : $clog2(nregs);
  endfunction

  localparam int unsigned DEF_AW = addr_width(DEF_NREGS);

  typedef logic [DEF_AW-1:0]   addr_t;
  typedef logic [DEF_XLEN-1:0] word_t;

endpackage

// File: rtl/rf_read_port.sv
// One read port: same-cycle write bypass (highest write port wins), zero-register
// forcing and pending/busy qualification.
module rf_read_port #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned AW      = 5,
  parameter int unsigned NWR     = 2,
  parameter bit          BYPASS  = 1'b1,
  parameter bit          ZERO_R0 = 1'b1
) (
  input  logic [AW-1:0]       ra,
  input  logic [XLEN-1:0]     stored,
  input  logic                pend,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   wa,
  input  logic [NWR*XLEN-1:0] wd,
  output logic [XLEN-1:0]     rd_c,
  output logic                busy_c
);

  logic            hit;
  logic [XLEN-1:0] byp;

  always_comb begin
    hit    = 1'b0;
    byp    = '0;
    if (BYPASS) begin
      // Ascending scan so the highest-index matching port is the one left standing.
      for (int j = 0; j < int'(NWR); j++) begin
        if (we[j] && (wa[j*AW +: AW] == ra)) begin
          hit = 1'b1;
          byp = wd[j*XLEN +: XLEN];
        end
      end
    end
    rd_c   = hit ? byp : stored;
    busy_c = pend && !hit;
    if (ZERO_R0 && (ra == '0)) begin
      rd_c   = '0;
      busy_c = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file: storage, prioritised writes, pending
// scoreboard for multicycle writebacks and an unbypassed debug read port.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned  XLEN    = DEF_XLEN,
  parameter int unsigned  NREGS   = DEF_NREGS,
  parameter int unsigned  NRD     = DEF_NRD,
  parameter int unsigned  NWR     = DEF_NWR,
  parameter bit           BYPASS  = 1'b1,
  parameter bit           ZERO_R0 = 1'b1,
  localparam int unsigned AW      = addr_width(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   wa,
  input  logic [NWR*XLEN-1:0] wd,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_addr,
  input  logic [AW-1:0]       dbg_addr,
  output logic [XLEN-1:0]     dbg_data,
  output logic                any_pend
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] pending;
  logic [NREGS-1:0] pending_nxt;

  // Writebacks clear first, then an issue to the same register re-marks it.
  always_comb begin
    pending_nxt = pending;
    for (int j = 0; j < int'(NWR); j++) begin
      if (we[j]) pending_nxt[wa[j*AW +: AW]] = 1'b0;
    end
    if (iss_valid && !(ZERO_R0 && (iss_addr == '0))) pending_nxt[iss_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
      pending <= '0;
    end else begin
      // Later (higher-index) ports overwrite earlier ones on an address clash.
      for (int j = 0; j < int'(NWR); j++) begin
        if (we[j] && !(ZERO_R0 && (wa[j*AW +: AW] == '0))) begin
          regs[wa[j*AW +: AW]] <= wd[j*XLEN +: XLEN];
        end
      end
      pending <= pending_nxt;
    end
  end

  assign dbg_data = regs[dbg_addr];
  assign any_pend = |pending;

  for (genvar i = 0; i < int'(NRD); i++) begin : g_rd
    logic [AW-1:0] ra_i;
    assign ra_i = ra[i*AW +: AW];

    rf_read_port #(
      .XLEN    (XLEN),
      .AW      (AW),
      .NWR     (NWR),
      .BYPASS  (BYPASS),
      .ZERO_R0 (ZERO_R0)
    ) u_rp (
      .ra     (ra_i),
      .stored (regs[ra_i]),
      .pend   (pending[ra_i]),
      .we     (we),
      .wa     (wa),
      .wd     (wd),
      .rd_c   (rd[i*XLEN +: XLEN]),
      .busy_c (rd_busy[i])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed scoreboard bench for regfile_mp (default 32x32, 2R/2W, bypass, zero r0).
module tb_regfile_mp;

  localparam int unsigned AW = 5;
  localparam int unsigned XL = 32;

  localparam int S_RD0 = 0, S_RD1 = 1, S_BUSY0 = 2, S_BUSY1 = 3, S_DBG = 4, S_ANY = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [2*AW-1:0] ra;
  logic [2*XL-1:0] rd;
  logic [1:0]    rd_busy;
  logic [1:0]    we;
  logic [2*AW-1:0] wa;
  logic [2*XL-1:0] wd;
  logic          iss_valid;
  logic [AW-1:0] iss_addr;
  logic [AW-1:0] dbg_addr;
  logic [XL-1:0] dbg_data;
  logic          any_pend;

  regfile_mp dut (
    .clk       (clk),
    .rst       (rst),
    .ra        (ra),
    .rd        (rd),
    .rd_busy   (rd_busy),
    .we        (we),
    .wa        (wa),
    .wd        (wd),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data),
    .any_pend  (any_pend)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          sig;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   nvec = 0;
  int   nerr = 0;

  function automatic logic [31:0] actual(input int sig);
    case (sig)
      S_RD0:   return rd[0 +: XL];
      S_RD1:   return rd[XL +: XL];
      S_BUSY0: return {31'd0, rd_busy[0]};
      S_BUSY1: return {31'd0, rd_busy[1]};
      S_DBG:   return dbg_data;
      default: return {31'd0, any_pend};
    endcase
  endfunction

  // Monitor: outputs are combinational, so everything queued during a cycle is checked at its negedge.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] a;
      e = q.pop_front();
      a = actual(e.sig);
      nvec++;
      if (a !== e.val) begin
        nerr++;
        $display("FAIL %s: got %h expected %h", e.name, a, e.val);
      end
    end
  end

  task automatic expect_v(input string name, input int sig, input logic [31:0] v);
    q.push_back('{name, sig, v});
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    rst       = 1'b0;
    we        = '0;
    iss_valid = 1'b0;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] d);
    ra[0 +: AW]  = a0;
    ra[AW +: AW] = a1;
    dbg_addr     = d;
  endtask

  task automatic wr(input int port, input logic [AW-1:0] a, input logic [XL-1:0] d);
    we[port]          = 1'b1;
    wa[port*AW +: AW] = a;
    wd[port*XL +: XL] = d;
  endtask

  task automatic issue(input logic [AW-1:0] a);
    iss_valid = 1'b1;
    iss_addr  = a;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ra = '0; we = '0; wa = '0; wd = '0;
    iss_valid = 1'b0; iss_addr = '0; dbg_addr = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    // Reset state
    set_rd(5'd3, 5'd8, 5'd8);
    expect_v("reset_rd0", S_RD0, 32'h0);
    expect_v("reset_rd1", S_RD1, 32'h0);
    expect_v("reset_busy0", S_BUSY0, 32'h0);
    expect_v("reset_dbg", S_DBG, 32'h0);
    expect_v("reset_any", S_ANY, 32'h0);

    // 1: preload, mark pending, then reset with concurrent write/issue
    next_cycle(); wr(0, 5'd3, 32'h0000_1234);
    next_cycle(); wr(0, 5'd4, 32'h0000_0055); issue(5'd5);
    next_cycle(); set_rd(5'd3, 5'd5, 5'd4);
    expect_v("preload_rd0", S_RD0, 32'h0000_1234);
    expect_v("preload_busy1", S_BUSY1, 32'h1);
    expect_v("preload_dbg", S_DBG, 32'h0000_0055);
    expect_v("preload_any", S_ANY, 32'h1);
    next_cycle(); rst = 1'b1; wr(0, 5'd6, 32'h0000_0099); issue(5'd7);
    next_cycle(); set_rd(5'd3, 5'd6, 5'd4);
    expect_v("rst_rd0", S_RD0, 32'h0);
    expect_v("rst_rd1_ignored_we", S_RD1, 32'h0);
    expect_v("rst_dbg", S_DBG, 32'h0);
    expect_v("rst_any", S_ANY, 32'h0);
    set_rd(5'd3, 5'd3, 5'd4);
    next_cycle(); set_rd(5'd7, 5'd5, 5'd6);
    expect_v("rst_busy0", S_BUSY0, 32'h0);
    expect_v("rst_busy1", S_BUSY1, 32'h0);
    expect_v("rst_dbg6", S_DBG, 32'h0);

    // 2: write then read
    next_cycle(); wr(0, 5'd8, 32'hDEAD_BEEF);
    next_cycle(); set_rd(5'd0, 5'd8, 5'd8);
    expect_v("wr_rd1", S_RD1, 32'hDEAD_BEEF);
    expect_v("wr_dbg", S_DBG, 32'hDEAD_BEEF);

    // 3: bypass vs stored debug view
    next_cycle(); wr(0, 5'd9, 32'h0000_0077);
    next_cycle(); wr(0, 5'd9, 32'h0000_0005); set_rd(5'd9, 5'd8, 5'd9);
    expect_v("byp_rd0", S_RD0, 32'h0000_0005);
    expect_v("byp_dbg_old", S_DBG, 32'h0000_0077);
    next_cycle(); set_rd(5'd9, 5'd8, 5'd9);
    expect_v("byp_dbg_new", S_DBG, 32'h0000_0005);

    // 4: two-port conflict, higher port wins
    next_cycle(); wr(0, 5'd10, 32'h1); wr(1, 5'd10, 32'h2); set_rd(5'd10, 5'd8, 5'd10);
    expect_v("conf_byp_rd0", S_RD0, 32'h2);
    expect_v("conf_dbg_old", S_DBG, 32'h0);
    next_cycle(); set_rd(5'd8, 5'd10, 5'd10);
    expect_v("conf_rd1", S_RD1, 32'h2);
    expect_v("conf_dbg", S_DBG, 32'h2);

    // 5: zero register
    next_cycle(); wr(1, 5'd0, 32'hFFFF_FFFF); issue(5'd0); set_rd(5'd0, 5'd10, 5'd0);
    expect_v("zero_byp_rd0", S_RD0, 32'h0);
    expect_v("zero_busy0", S_BUSY0, 32'h0);
    next_cycle(); set_rd(5'd0, 5'd0, 5'd0);
    expect_v("zero_rd0", S_RD0, 32'h0);
    expect_v("zero_rd1", S_RD1, 32'h0);
    expect_v("zero_dbg", S_DBG, 32'h0);
    expect_v("zero_any", S_ANY, 32'h0);

    // 6: scoreboard
    next_cycle(); issue(5'd11); set_rd(5'd11, 5'd12, 5'd11);
    expect_v("sb_issue_busy_same", S_BUSY0, 32'h0);
    next_cycle(); set_rd(5'd11, 5'd12, 5'd11);
    expect_v("sb_busy0", S_BUSY0, 32'h1);
    expect_v("sb_busy1_other", S_BUSY1, 32'h0);
    expect_v("sb_any", S_ANY, 32'h1);
    next_cycle(); wr(1, 5'd11, 32'h7); set_rd(5'd11, 5'd12, 5'd11);
    expect_v("sb_wb_busy_byp", S_BUSY0, 32'h0);
    expect_v("sb_wb_rd0", S_RD0, 32'h7);
    expect_v("sb_wb_any_still", S_ANY, 32'h1);
    next_cycle(); set_rd(5'd11, 5'd12, 5'd11);
    expect_v("sb_clr_busy", S_BUSY0, 32'h0);
    expect_v("sb_clr_any", S_ANY, 32'h0);
    expect_v("sb_clr_dbg", S_DBG, 32'h7);
    next_cycle(); issue(5'd11); wr(0, 5'd11, 32'h8);
    next_cycle(); set_rd(5'd11, 5'd12, 5'd11);
    expect_v("sb_setwin_busy", S_BUSY0, 32'h1);
    expect_v("sb_setwin_any", S_ANY, 32'h1);
    expect_v("sb_setwin_rd0", S_RD0, 32'h8);
    next_cycle(); rst = 1'b1;
    next_cycle(); set_rd(5'd11, 5'd12, 5'd11);
    expect_v("sb_rst_busy", S_BUSY0, 32'h0);
    expect_v("sb_rst_any", S_ANY, 32'h0);
    expect_v("sb_rst_rd0", S_RD0, 32'h0);
    next_cycle(); wr(0, 5'd11, 32'h9);
    next_cycle(); set_rd(5'd11, 5'd12, 5'd11);
    expect_v("late_wb_rd0", S_RD0, 32'h9);
    expect_v("late_wb_busy", S_BUSY0, 32'h0);
    expect_v("late_wb_any", S_ANY, 32'h0);

    @(negedge clk);
    #1;
    nvec++;
    if (q.size() != 0) begin
      nerr++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
